// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake between a producer and the UART transmit FIFO.
// The producer offers tx_byte with tx_dv; the FIFO reports room on tx_ready.
interface uart_tx_fifo_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_ready
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 LSB-first UART transmitter fed by a 4-entry byte FIFO.
// Buffered bytes go out back to back, one idle cycle between frames.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           i_Clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  tx_if,
  output logic           o_Tx_Serial,
  output logic           o_Tx_Active,
  output logic           o_Tx_Done,
  output logic           o_Tx_Overflow
);

  localparam int unsigned FifoDepth = 4;
  localparam logic [15:0] TermCnt   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FifoDepth];

  logic tx_ready;
  logic push;
  logic pop;

  // Ready uses the pre-edge count, so a push at full is refused even if IDLE pops.
  assign tx_ready = (count_q != 3'd4);
  assign push     = tx_if.tx_dv && tx_ready;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (tx_if.tx_dv & ~tx_ready);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (count_q != 3'd0) begin
          shift_d  = mem_q[rd_ptr_q];
          pop      = 1'b1;
          cnt_d    = 16'd0;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (cnt_q == TermCnt) begin
          serial_d  = shift_q[0];
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == TermCnt) begin
          cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_d];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == TermCnt) begin
          cnt_d    = 16'd0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        cnt_d     = 16'd0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= 3'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= tx_if.tx_byte;
    end
  end

  assign tx_if.tx_ready = tx_ready;
  assign o_Tx_Serial    = serial_q;
  assign o_Tx_Active    = active_q;
  assign o_Tx_Done      = done_q;
  assign o_Tx_Overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (CLKS_PER_BIT 4 and 2) with a
// line-decoding receiver model per instance; all checks use hand-computed values.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if if_a ();
  uart_tx_fifo_if if_b ();

  logic ser_a, act_a, done_a, ovf_a;
  logic ser_b, act_b, done_b, ovf_b;

  uart_tx_fifo #(.CLKS_PER_BIT(4)) dut_a (
    .i_Clock       (clk),
    .reset         (rst),
    .tx_if         (if_a),
    .o_Tx_Serial   (ser_a),
    .o_Tx_Active   (act_a),
    .o_Tx_Done     (done_a),
    .o_Tx_Overflow (ovf_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(2)) dut_b (
    .i_Clock       (clk),
    .reset         (rst),
    .tx_if         (if_b),
    .o_Tx_Serial   (ser_b),
    .o_Tx_Active   (act_b),
    .o_Tx_Done     (done_b),
    .o_Tx_Overflow (ovf_b)
  );

  logic [7:0] rxq_a[$];
  logic [7:0] rxq_b[$];
  int         startq_a[$];
  int         startq_b[$];
  int         doneq_a[$];
  int         doneq_b[$];
  int         glitch_a = 0, glitch_b = 0, ferr_a = 0, ferr_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int which);
    return (which == 0) ? ser_a : ser_b;
  endfunction

  function automatic logic act_of(input int which);
    return (which == 0) ? act_a : act_b;
  endfunction

  function automatic logic done_of(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction

  always @(negedge clk) begin
    if (done_a === 1'b1) doneq_a.push_back(cyc);
    if (done_b === 1'b1) doneq_b.push_back(cyc);
  end

  // Receiver model: samples every cycle of a frame, decodes at bit centres,
  // counts intra-bit glitches and framing/active/done errors; aborts on reset.
  task automatic monitor(input int which);
    int          cpb;
    int          st;
    int          g;
    int          fe;
    bit          abort;
    logic [39:0] smp;
    logic [7:0]  b;
    logic        v;
    cpb = (which == 0) ? 4 : 2;
    forever begin
      @(negedge clk);
      if (line_of(which) === 1'b0 && rst === 1'b0) begin
        st    = cyc;
        abort = 1'b0;
        fe    = 0;
        g     = 0;
        smp   = '0;
        for (int j = 0; j < 10 * cpb; j++) begin
          if (j > 0) @(negedge clk);
          if (rst !== 1'b0) abort = 1'b1;
          smp[j] = line_of(which);
          if (act_of(which) !== 1'b1) fe++;
          if (done_of(which) !== 1'b0) fe++;
        end
        if (!abort) begin
          b = '0;
          for (int k = 0; k < 10; k++) begin
            v = smp[k * cpb + cpb / 2];
            for (int j = 0; j < cpb; j++) begin
              if (smp[k * cpb + j] !== v) g++;
            end
            if (k == 0 && v !== 1'b0) fe++;
            if (k == 9 && v !== 1'b1) fe++;
            if (k >= 1 && k <= 8) b[k - 1] = v;
          end
          if (which == 0) begin
            rxq_a.push_back(b);
            startq_a.push_back(st);
            glitch_a += g;
            ferr_a   += fe;
          end else begin
            rxq_b.push_back(b);
            startq_b.push_back(st);
            glitch_b += g;
            ferr_b   += fe;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic drive(input int which, input logic dv, input logic [7:0] b);
    if (which == 0) begin
      if_a.tx_dv   = dv;
      if_a.tx_byte = b;
    end else begin
      if_b.tx_dv   = dv;
      if_b.tx_byte = b;
    end
  endtask

  // Called just after a negedge; returns the cycle number of the accepting edge.
  task automatic push_one(input int which, input logic [7:0] b, output int acc);
    drive(which, 1'b1, b);
    acc = cyc + 1;
    @(negedge clk);
    drive(which, 1'b0, 8'h00);
  endtask

  task automatic wait_rx(input int which, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (which == 0 && rxq_a.size() >= n && doneq_a.size() >= n) break;
      if (which == 1 && rxq_b.size() >= n && doneq_b.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic clear_a();
    rxq_a.delete();
    startq_a.delete();
    doneq_a.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int         acc;
    int         acc0;
    logic       rdy_all;
    logic [5:0] rdyvec;
    logic [7:0] burst [4];
    logic [7:0] full5 [5];
    int         n;
    int         budget;

    burst = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    full5 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("reset_serial", ser_a, 1'b1);
    check_eq("reset_active", act_a, 1'b0);
    check_eq("reset_done", done_a, 1'b0);
    check_eq("reset_overflow", ovf_a, 1'b0);
    check_eq("reset_ready", if_a.tx_ready, 1'b1);
    check_eq("reset_serial_b", ser_b, 1'b1);

    // Single byte 0xA5
    clear_a();
    push_one(0, 8'hA5, acc);
    check_eq("a5_line_idle_after_accept", ser_a, 1'b1);
    wait_rx(0, 1, 200);
    check_eq("a5_frames", rxq_a.size(), 1);
    check_eq("a5_dones", doneq_a.size(), 1);
    if (rxq_a.size() > 0) begin
      check_eq("a5_byte", rxq_a[0], 8'hA5);
      check_eq("a5_latency", startq_a[0] - acc, 1);
    end
    if (doneq_a.size() > 0) check_eq("a5_done_cycle", doneq_a[0] - acc, 41);
    check_eq("a5_glitches", glitch_a, 0);
    check_eq("a5_framing", ferr_a, 0);
    check_eq("a5_idle_after", ser_a, 1'b1);

    // Burst of four on consecutive cycles
    repeat (10) @(negedge clk);
    clear_a();
    rdy_all = 1'b1;
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      rdy_all &= if_a.tx_ready;
      drive(0, 1'b1, burst[i]);
      if (i == 0) acc0 = cyc + 1;
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    check_eq("burst_ready_high", rdy_all, 1'b1);
    wait_rx(0, 4, 400);
    check_eq("burst_frames", rxq_a.size(), 4);
    check_eq("burst_dones", doneq_a.size(), 4);
    n = (rxq_a.size() < 4) ? rxq_a.size() : 4;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("burst_byte%0d", i), rxq_a[i], burst[i]);
      check_eq($sformatf("burst_start%0d", i), startq_a[i] - acc0, 1 + 41 * i);
    end
    if (doneq_a.size() > 0) check_eq("burst_done0", doneq_a[0] - acc0, 41);

    // Full / overflow: six pushes on consecutive cycles
    repeat (10) @(negedge clk);
    clear_a();
    rdyvec = '0;
    for (int i = 0; i < 6; i++) begin
      rdyvec[i] = if_a.tx_ready;
      drive(0, 1'b1, 8'(8'h11 * (i + 1)));
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    check_eq("ovf_ready_pattern", rdyvec, 6'b011111);
    check_eq("ovf_flag_set", ovf_a, 1'b1);
    budget = 6 * 41 + 60;
    repeat (budget) @(negedge clk);
    check_eq("ovf_frames", rxq_a.size(), 5);
    check_eq("ovf_dones", doneq_a.size(), 5);
    n = (rxq_a.size() < 5) ? rxq_a.size() : 5;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("ovf_byte%0d", i), rxq_a[i], 8'(8'h11 * (i + 1)));
    end
    check_eq("ovf_sticky", ovf_a, 1'b1);

    // Simultaneous push/pop at full
    do_reset();
    check_eq("full_ovf_cleared", ovf_a, 1'b0);
    clear_a();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, full5[i]);
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    check_eq("full_ready_low", if_a.tx_ready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (done_a === 1'b1) break;
      @(negedge clk);
    end
    check_eq("full_done_seen", done_a, 1'b1);
    check_eq("full_ready_at_pop", if_a.tx_ready, 1'b0);
    check_eq("full_ovf_before", ovf_a, 1'b0);
    drive(0, 1'b1, 8'hEE);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check_eq("full_push_rejected_ovf", ovf_a, 1'b1);
    check_eq("full_ready_after_pop", if_a.tx_ready, 1'b1);
    budget = 5 * 41 + 60;
    repeat (budget) @(negedge clk);
    check_eq("full_frames", rxq_a.size(), 5);
    n = (rxq_a.size() < 5) ? rxq_a.size() : 5;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("full_byte%0d", i), rxq_a[i], full5[i]);
    end

    // Reset during d3 of 0x81 with two bytes queued
    do_reset();
    clear_a();
    push_one(0, 8'h81, acc);
    drive(0, 1'b1, 8'h01);
    @(negedge clk);
    drive(0, 1'b1, 8'h02);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    while (cyc < acc + 18) @(negedge clk);
    check_eq("rst_mid_active_before", act_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_serial", ser_a, 1'b1);
    check_eq("rst_mid_active", act_a, 1'b0);
    check_eq("rst_mid_ready", if_a.tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("rst_mid_no_frames", rxq_a.size(), 0);
    check_eq("rst_mid_no_done", doneq_a.size(), 0);
    check_eq("rst_mid_line_idle", ser_a, 1'b1);
    push_one(0, 8'h3C, acc);
    wait_rx(0, 1, 200);
    check_eq("rst_after_frames", rxq_a.size(), 1);
    if (rxq_a.size() > 0) begin
      check_eq("rst_after_byte", rxq_a[0], 8'h3C);
      check_eq("rst_after_latency", startq_a[0] - acc, 1);
    end

    // Minimum bit period on the second instance
    push_one(1, 8'h96, acc);
    wait_rx(1, 1, 100);
    check_eq("min_frames", rxq_b.size(), 1);
    if (rxq_b.size() > 0) begin
      check_eq("min_byte", rxq_b[0], 8'h96);
      check_eq("min_latency", startq_b[0] - acc, 1);
    end
    if (doneq_b.size() > 0) check_eq("min_done_cycle", doneq_b[0] - acc, 21);
    check_eq("min_glitches", glitch_b, 0);
    check_eq("min_framing", ferr_b, 0);

    check_eq("all_glitches_a", glitch_a, 0);
    check_eq("all_framing_a", ferr_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial UART transmitter, 8N1, LSB first, with a 4-entry byte FIFO in front of the shifter. It is the transmit-side companion of the UART receive path and uses the same bit-period parameter, so a TX/RX pair built from one `CLKS_PER_BIT` value interoperates. Fabric logic pushes bytes through a valid/ready handshake. The block drives `o_Tx_Serial` directly to the pad or loopback path and sends buffered bytes back to back without software pacing.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range 2..65535.
- `FIFO_DEPTH`, fixed at 4: byte buffer depth. Not a user parameter.
- `i_Clock`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_Tx_DV`  in  1  byte-valid strobe from the producer.
- `i_Tx_Byte`  in  8  byte to send, sampled when `i_Tx_DV` is high.
- `o_Tx_Ready`  out  1  FIFO not full. Combinational from the FIFO count.
- `o_Tx_Serial`  out  1  serial line, registered. Idle level is 1.
- `o_Tx_Active`  out  1  high while a frame (start, data or stop) is being driven.
- `o_Tx_Done`  out  1  one-cycle pulse after each stop bit completes.
- `o_Tx_Overflow`  out  1  sticky flag, set when a byte is offered while the FIFO is full.

## Operation
- **Reset values:**
  - `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Tx_Overflow`=0, `o_Tx_Ready`=1.
  - FIFO count and pointers = 0, state = IDLE, bit counter = 0, bit index = 0.
- **Push:**
  - A byte is written when `i_Tx_DV` && `o_Tx_Ready` at a clock edge.
  - `i_Tx_DV` while full drops the byte and sets `o_Tx_Overflow`. It stays set until reset.
- **Pop:** the FIFO is popped only by the state machine in IDLE.
  - Push and pop in the same cycle leave the count unchanged, including when full. Ready is based on the pre-edge count, so a push at count=4 is rejected even when a pop occurs.
  - Pointers are 2-bit and wrap naturally. The count is 3-bit, range 0..4.
- **IDLE:**
  - `o_Tx_Serial`=1, `o_Tx_Active`=0.
  - If count>0: load the head byte into the shift register, pop, clear the bit counter, drive `o_Tx_Serial`=0, set `o_Tx_Active`=1, go to START.
- **START:** hold 0 for `CLKS_PER_BIT` cycles. On the terminal count, drive bit 0, clear the counter and bit index, go to DATA.
- **DATA:**
  - Each bit is held `CLKS_PER_BIT` cycles.
  - On the terminal count with index<7: increment the index and drive the next bit.
  - On the terminal count with index=7: drive 1 and go to STOP.
- **STOP:** hold 1 for `CLKS_PER_BIT` cycles. On the terminal count:
  - `o_Tx_Done`=1 for one cycle;
  - `o_Tx_Active`=0;
  - go to IDLE.
- **Counter:** 16-bit. Terminal count is `CLKS_PER_BIT`-1.
- **Byte stability:** the producer may change `i_Tx_Byte` freely once the byte is accepted. The transmitted byte comes from the FIFO copy.
- **Illegal states** (3-bit encoding) return to IDLE with the line high.

## Timing
- **Latency:** byte accepted at edge E into an empty FIFO with the state machine idle → `o_Tx_Serial` falls after edge E+1.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles of line activity. Start low for `CLKS_PER_BIT` cycles, then d0..d7, then stop.
- **`o_Tx_Done`:** high during the first IDLE cycle after the frame.
- **Back-to-back:**
  - The next start bit begins one cycle after `o_Tx_Done`, giving a frame period of `10*CLKS_PER_BIT`+1 cycles.
  - The line is high for `CLKS_PER_BIT`+1 cycles between frames (stop plus one idle cycle).
- **`o_Tx_Ready`:** deasserts in the cycle the count reaches 4 and reasserts in the cycle after a pop from full.
- **Reset mid-frame:**
  - The line returns to 1 on the edge after `reset` is sampled high.
  - Buffered bytes are discarded; no partial frame resumes.
- **Reset during a push:** reset wins; the byte is dropped.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=4, push 0xA5 at idle.
  - Line low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - `o_Tx_Done` pulses at cycle 41 after acceptance.
  - A loopback `uart_rx` with the same `CLKS_PER_BIT` reports 0xA5.
- **Burst:** push 0x00, 0xFF, 0x55, 0x3C on consecutive cycles.
  - `o_Tx_Ready` stays high; the count peaks at 3 because the first byte pops at E+1.
  - Four frames at a 41-cycle period, received in order, four `o_Tx_Done` pulses.
- **Full/overflow:** hold the line busy and push 6 bytes on consecutive cycles.
  - `o_Tx_Ready` drops after the 5th accepted byte (1 in the shifter, 4 in the FIFO).
  - The 6th byte is dropped and `o_Tx_Overflow`=1 sticky.
  - Exactly 5 frames are sent.
- **Simultaneous push/pop at full:** count=4, push while IDLE pops.
  - Push rejected and `o_Tx_Overflow` set.
  - Count becomes 3, then `o_Tx_Ready`=1.
- **Reset mid-frame:** assert `reset` during d3 of 0x81 with 2 bytes queued.
  - `o_Tx_Serial`=1 and `o_Tx_Active`=0 the next cycle, FIFO empty, no `o_Tx_Done`.
  - The next push sends a clean frame.
- **Minimum `CLKS_PER_BIT`=2:** push 0x96 → 20-cycle frame, bits correct, loopback RX decodes 0x96.
